// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the three-port SRAM arbiter:
// request, lock and access fields in; grant, read valid and read data out.
interface sram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic [2:0]              req;
   logic [2:0]              lock;
   logic [2:0]              we;
   logic [3*ADDR_WIDTH-1:0] addr;
   logic [3*DATA_WIDTH-1:0] din;
   logic [2:0]              gnt;
   logic [2:0]              rvalid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    lock_timeout;

   modport slave (
      input  req, lock, we, addr, din,
      output gnt, rvalid, rdata, lock_timeout
   );

   modport master (
      output req, lock, we, addr, din,
      input  gnt, rvalid, rdata, lock_timeout
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Three-requester round-robin arbiter for a single-port synchronous SRAM,
// with bounded burst locking and forced release after MAX_LOCK beats.
module sram_port_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LOCK   = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   sram_port_arbiter_if.slave    bus,
   output logic                  o_mem_cs,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_din,
   input  logic [DATA_WIDTH-1:0] i_mem_dout
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t     r_fsm;
   logic [1:0] r_rr;
   logic [1:0] r_owner;
   logic [7:0] r_beat;
   logic [2:0] r_rvalid;
   logic       r_timeout;

   logic [1:0] w_c1;
   logic [1:0] w_c2;
   logic [1:0] w_win;
   logic       w_win_vld;
   logic [1:0] w_sel;
   logic       w_go;
   logic [2:0] w_gnt;
   logic [7:0] w_beat_nx;
   logic       w_max;

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // cyclic search starting at the round-robin pointer
   always_comb begin
      w_c1      = inc3(r_rr);
      w_c2      = inc3(w_c1);
      w_win     = r_rr;
      w_win_vld = 1'b1;
      if (bus.req[r_rr])      w_win = r_rr;
      else if (bus.req[w_c1]) w_win = w_c1;
      else if (bus.req[w_c2]) w_win = w_c2;
      else                    w_win_vld = 1'b0;
   end

   assign w_sel = (r_fsm == LOCKED) ? r_owner : w_win;
   assign w_go  = ~i_rst &
                  ((r_fsm == LOCKED) ? bus.req[r_owner] : w_win_vld);
   assign w_gnt = w_go ? (3'b001 << w_sel) : 3'b000;

   assign w_beat_nx = r_beat + 8'd1;
   assign w_max     = (w_beat_nx == 8'(MAX_LOCK));

   assign o_mem_cs   = w_go;
   assign o_mem_we   = w_go & bus.we[w_sel];
   assign o_mem_addr = w_go ?
      bus.addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign o_mem_din  = w_go ?
      bus.din[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH] : '0;

   assign bus.gnt          = w_gnt;
   assign bus.rvalid       = r_rvalid;
   assign bus.rdata        = i_mem_dout;
   assign bus.lock_timeout = r_timeout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fsm     <= IDLE;
         r_rr      <= 2'd0;
         r_owner   <= 2'd0;
         r_beat    <= 8'd0;
         r_rvalid  <= 3'b000;
         r_timeout <= 1'b0;
      end else begin
         r_rvalid  <= w_gnt & ~bus.we;
         r_timeout <= 1'b0;
         unique case (r_fsm)
            IDLE: begin
               if (w_go) begin
                  // a one-beat limit releases immediately as a timeout
                  if (bus.lock[w_win] && MAX_LOCK > 1) begin
                     r_fsm   <= LOCKED;
                     r_owner <= w_win;
                     r_beat  <= 8'd1;
                  end else begin
                     r_rr      <= inc3(w_win);
                     r_timeout <= bus.lock[w_win];
                  end
               end
            end
            LOCKED: begin
               if (!w_go || !bus.lock[r_owner] || w_max) begin
                  r_fsm     <= IDLE;
                  r_rr      <= inc3(r_owner);
                  r_beat    <= 8'd0;
                  r_timeout <= w_go & bus.lock[r_owner] & w_max;
               end else begin
                  r_beat <= w_beat_nx;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small synchronous SRAM model;
// built with MAX_LOCK = 4 so forced release is reachable quickly.
module tb_sram_port_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk;
   logic          rst;
   logic          mem_cs;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] mem [16];
   logic [15:0]   wr_vld;

   int n_chk;
   int n_err;

   sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sram_port_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_LOCK  (4)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .bus        (bus.slave),
      .o_mem_cs   (mem_cs),
      .o_mem_we   (mem_we),
      .o_mem_addr (mem_addr),
      .o_mem_din  (mem_din),
      .i_mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   // unwritten locations read 8'h30+addr, except address 5 which holds A5
   always @(posedge clk) begin
      if (rst) begin
         wr_vld <= '0;
      end else if (mem_cs) begin
         if (mem_we) begin
            mem[mem_addr]    <= mem_din;
            wr_vld[mem_addr] <= 1'b1;
         end else if (wr_vld[mem_addr]) begin
            mem_dout <= mem[mem_addr];
         end else if (mem_addr == 4'd5) begin
            mem_dout <= 8'hA5;
         end else begin
            mem_dout <= 8'h30 + {4'h0, mem_addr};
         end
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] r,
                        input logic [2:0] l,
                        input logic [2:0] w);
      bus.req  = r;
      bus.lock = l;
      bus.we   = w;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] eg [6];
   logic [7:0] ed [6];

   initial begin
      n_chk = 0;
      n_err = 0;
      clk   = 1'b0;
      rst   = 1'b1;
      bus.addr = {4'd9, 4'd5, 4'd1};
      bus.din  = {8'hC2, 8'hB1, 8'hA0};
      drive(3'b111, 3'b000, 3'b000);
      eg = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      ed = '{8'h31, 8'hA5, 8'h39, 8'h31, 8'hA5, 8'h39};

      repeat (2) @(posedge clk);
      #2;
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_cs", 32'(mem_cs), 32'h0);
      check("rst_rvalid", 32'(bus.rvalid), 32'h0);
      check("rst_to", 32'(bus.lock_timeout), 32'h0);
      rst = 1'b0;

      // three-way round robin with back-to-back reads
      for (int k = 0; k < 6; k++) begin
         #1;
         check("rr_gnt", 32'(bus.gnt), 32'(eg[k]));
         check("rr_cs", 32'(mem_cs), 32'h1);
         if (k > 0) begin
            check("rr_rvalid", 32'(bus.rvalid), 32'(eg[k-1]));
            check("rr_rdata", 32'(bus.rdata), 32'(ed[k-1]));
         end
         step();
      end

      // single read by requester 1 at address 5
      drive(3'b010, 3'b000, 3'b000);
      #1;
      check("rd_gnt", 32'(bus.gnt), 32'h2);
      check("rd_addr", 32'(mem_addr), 32'h5);
      check("rd_we", 32'(mem_we), 32'h0);
      step();
      drive(3'b000, 3'b000, 3'b000);
      #1;
      check("rd_rvalid", 32'(bus.rvalid), 32'h2);
      check("rd_rdata", 32'(bus.rdata), 32'hA5);
      check("idle_cs", 32'(mem_cs), 32'h0);
      check("idle_addr", 32'(mem_addr), 32'h0);
      step();

      // write then read-back by requester 0
      drive(3'b001, 3'b000, 3'b001);
      #1;
      check("wr_gnt", 32'(bus.gnt), 32'h1);
      check("wr_we", 32'(mem_we), 32'h1);
      check("wr_din", 32'(mem_din), 32'hA0);
      step();
      drive(3'b001, 3'b000, 3'b000);
      #1;
      check("wr_norv", 32'(bus.rvalid), 32'h0);
      check("rb_gnt", 32'(bus.gnt), 32'h1);
      step();
      drive(3'b000, 3'b000, 3'b000);
      #1;
      check("rb_rvalid", 32'(bus.rvalid), 32'h1);
      check("rb_rdata", 32'(bus.rdata), 32'hA0);
      step();

      // pointer to 0, then requester 0 locks 3 beats against req[2]
      drive(3'b100, 3'b000, 3'b000);
      #1;
      check("p0_gnt", 32'(bus.gnt), 32'h4);
      step();
      drive(3'b101, 3'b001, 3'b000);
      #1;
      check("lk_gnt1", 32'(bus.gnt), 32'h1);
      step();
      #1;
      check("lk_gnt2", 32'(bus.gnt), 32'h1);
      check("lk_addr", 32'(mem_addr), 32'h1);
      step();
      drive(3'b101, 3'b000, 3'b000);
      #1;
      check("lk_gnt3", 32'(bus.gnt), 32'h1);
      step();
      #1;
      check("lk_next", 32'(bus.gnt), 32'h4);
      check("lk_noto", 32'(bus.lock_timeout), 32'h0);
      step();

      // pointer to 2, then requester 2 holds lock past MAX_LOCK
      drive(3'b010, 3'b000, 3'b000);
      #1;
      check("p2_gnt", 32'(bus.gnt), 32'h2);
      step();
      drive(3'b101, 3'b100, 3'b000);
      for (int k = 0; k < 4; k++) begin
         #1;
         check("to_gnt", 32'(bus.gnt), 32'h4);
         check("to_early", 32'(bus.lock_timeout), 32'h0);
         step();
      end
      #1;
      check("to_rel", 32'(bus.gnt), 32'h1);
      check("to_pulse", 32'(bus.lock_timeout), 32'h1);
      step();
      drive(3'b000, 3'b000, 3'b000);
      #1;
      check("to_end", 32'(bus.lock_timeout), 32'h0);
      step();

      // requester 1 locked, then drops its request
      drive(3'b010, 3'b010, 3'b000);
      #1;
      check("dr_gnt1", 32'(bus.gnt), 32'h2);
      step();
      #1;
      check("dr_gnt2", 32'(bus.gnt), 32'h2);
      step();
      drive(3'b000, 3'b000, 3'b000);
      #1;
      check("dr_gap", 32'(bus.gnt), 32'h0);
      check("dr_cs", 32'(mem_cs), 32'h0);
      step();
      drive(3'b111, 3'b000, 3'b000);
      #1;
      check("dr_rr2", 32'(bus.gnt), 32'h4);
      step();
      #1;
      check("dr_rr0", 32'(bus.gnt), 32'h1);
      step();

      // reset in the middle of a locked read burst
      drive(3'b010, 3'b010, 3'b000);
      #1;
      check("rl_gnt1", 32'(bus.gnt), 32'h2);
      step();
      #1;
      check("rl_gnt2", 32'(bus.gnt), 32'h2);
      step();
      rst = 1'b1;
      drive(3'b111, 3'b000, 3'b000);
      #1;
      check("rl_rstgnt", 32'(bus.gnt), 32'h0);
      check("rl_rstcs", 32'(mem_cs), 32'h0);
      step();
      rst = 1'b0;
      #1;
      check("rl_gnt", 32'(bus.gnt), 32'h1);
      check("rl_rvalid", 32'(bus.rvalid), 32'h0);
      check("rl_to", 32'(bus.lock_timeout), 32'h0);
      step();
      #1;
      check("rl_rv2", 32'(bus.rvalid), 32'h1);
      check("rl_gnt2b", 32'(bus.gnt), 32'h2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
